mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
Sequential shift-add unsigned multiplier. It produces the product for the ALU's multiply slot (aluop 3'b010), which has no combinational multiplier. It takes the same 32-bit a/b operands the ALU sees and returns a 64-bit product. The low 32 bits are offered on a separate output that is wired straight into the ALU's mux input for aluop 010. Control logic starts it with a one-cycle start and waits for done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH, iteration count is WIDTH.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  multiplicand, captured on accepted start
b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high while iterating (RUN)
done  output  1  one-cycle pulse, product valid
product  output  2*WIDTH  full unsigned product, held until next completion
result  output  WIDTH  product[WIDTH-1:0], feeds the ALU aluop 010 input

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0; done=0; product=0; result=0; internal acc/mcand/mplier/count=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN.
  - RUN: moves to DONE when count==WIDTH-1.
  - DONE: lasts exactly 1 cycle. With start=1 it moves to RUN; otherwise it returns to IDLE.
- Accepted start at edge E0:
  - acc<=0.
  - mcand<={WIDTH'b0,a} (2*WIDTH wide).
  - mplier<=b.
  - count<=0.
- Each RUN edge:
  - if mplier[0], acc<=acc+mcand.
  - mcand<=mcand<<1.
  - mplier<=mplier>>1.
  - count<=count+1.
  - Addition is 2*WIDTH bits and cannot overflow.
- Timing: iterations occur at E1..E32 (WIDTH edges). At E32 the block loads product<=final acc and enters DONE. done is high for the cycle after E32.
  - Latency is WIDTH cycles from the start-sampling edge to done.
  - busy=1 exactly in RUN, which is the cycles after E0 through E32.
- product/result update only on the RUN->DONE edge. During RUN they hold the previous result.
- Inputs a/b changing during RUN have no effect. Only the values captured at start are used.
- start while busy=1 is ignored, not queued.
- start in DONE is accepted: back-to-back operation with no idle bubble. done still pulses for that cycle.
- start held high continuously produces repeated operations, one every WIDTH+1 cycles.
- Reset mid-RUN aborts immediately:
  - product=0, done=0, state=IDLE.
  - No done pulse after reset release.
- Unsigned only. The signed/Booth variant is out of scope.
- count width is clog2(WIDTH).

Decomposition:
- Shared package (alu_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - ALU opcode constant ALUOP_MUL=3'b010.
  - default WIDTH.
- One sub-module, mult_step: combinational single iteration. It takes acc, mcand, mplier and returns next acc, mcand, mplier. It is instantiated once inside the sequential wrapper.

Test Plan:
- Basic: a=3, b=5, pulse start.
  - busy high for 32 cycles.
  - done pulses 32 cycles after the start edge.
  - product=64'd15, result=32'd15.
- Max operands: a=b=32'hFFFFFFFF.
  - product=64'hFFFFFFFE00000001.
  - result=32'h00000001.
- Zero and hold: a=0, b=32'h12345678.
  - product=0.
  - A second start with a=32'h10000, b=32'h10000 gives product=64'h100000000 and result=0.
  - product holds 0 during the second RUN.
- Ignore while busy: start with a=7, b=6. At cycle 10 pulse start with a=9, b=9 and also change a/b mid-run.
  - Exactly one done pulse.
  - product=42.
- Back-to-back: keep start high through the DONE cycle with new operands a=2, b=32'h80000000.
  - First done, product=42.
  - Next RUN begins with no IDLE cycle.
  - Second done 33 cycles after the first, product=64'h100000000.
- Reset mid-op: assert rst_n low at cycle 15 of RUN.
  - busy, done and product go 0 immediately, without waiting for a clock edge.
  - After release, no done appears without a new start.
  - A new start with a=4, b=4 gives product=16.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its sequential multiplier.
//   MULT_WIDTH   : default operand width of the multiplier
//   ALUOP_MUL    : ALU opcode whose mux input is fed by mult32_seq.result
//   mult_state_e : multiplier control states (IDLE / RUN / DONE)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [2:0] ALUOP_MUL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// One combinational iteration of the shift-add unsigned multiplier.
//   acc_i      : running partial product (2*WIDTH)
//   mcand_i    : multiplicand, already shifted to the current bit weight (2*WIDTH)
//   mplier_i   : remaining multiplier bits, LSB is the bit being consumed (WIDTH)
//   acc_o      : acc_i + mcand_i when mplier_i[0] is set, else acc_i
//   mcand_o    : mcand_i shifted left by one
//   mplier_o   : mplier_i shifted right by one
// ---------------------------------------------------------------------------
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o
);

  // The accumulator is 2*WIDTH wide and the full product of two WIDTH-bit
  // unsigned values fits in it, so the add never needs a carry out.
  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/mult32_seq.sv
// ---------------------------------------------------------------------------
// mult32_seq
// Sequential shift-add unsigned multiplier serving the ALU multiply slot.
// A one-cycle start captures a/b; WIDTH iterations later done pulses and
// product/result hold the new value until the next completion.
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, honoured only in IDLE or DONE
//   a, b    : operands, captured on an accepted start
//   busy    : high while iterating
//   done    : one-cycle pulse when product/result are updated
//   product : full 2*WIDTH unsigned product
//   result  : low WIDTH bits of product (ALU aluop 010 input)
// ---------------------------------------------------------------------------
module mult32_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_e        state_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0]   mplier_d;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE for start acceptance, which gives
        // back-to-back operations without an idle bubble.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            count_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          count_q  <= count_q + CW'(1);
          // The last iteration's sum goes straight to product so done
          // lines up with the WIDTH-th iteration edge.
          if (count_q == LAST) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign result  = product_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult32_seq.sv
module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] result;

  int          checks   = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          cyc = 0;
  logic [63:0] sb[$];

  mult32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [63:0] exp;
      done_seen++;
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp = sb.pop_front();
        $display("done #%0d cyc=%0d product=%h result=%h exp=%h",
                 done_seen, cyc, product, result, exp);
        check("product", product, exp);
        check("result", {32'd0, result}, {32'd0, exp[31:0]});
      end
    end
  end

  // Called at a negedge: drives a one-cycle start, returns at the next negedge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic wait_done(output int lat, output int bcnt, output int at_cyc);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      lat++;
      @(negedge clk);
    end
    at_cyc = cyc;
    if (!done) check("timeout_done", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, bcnt, c1, c2, ds;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("rst_busy",    {63'd0, busy}, 64'd0);
    check("rst_done",    {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_result",  {32'd0, result}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3*5 with latency and busy length
    sb.push_back(64'd15);
    start_op(32'd3, 32'd5);
    wait_done(lat, bcnt, c1);
    check("basic_latency", 64'(lat), 64'd32);
    check("basic_busy_cycles", 64'(bcnt), 64'd32);
    @(negedge clk);
    check("idle_after_done_busy", {63'd0, busy}, 64'd0);

    // Max operands
    sb.push_back(64'hFFFFFFFE00000001);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bcnt, c1);
    @(negedge clk);

    // Zero operand, then product must hold 0 through the next run
    sb.push_back(64'd0);
    start_op(32'd0, 32'h12345678);
    wait_done(lat, bcnt, c1);
    @(negedge clk);
    sb.push_back(64'h100000000);
    start_op(32'h10000, 32'h10000);
    repeat (15) @(negedge clk);
    check("hold_product_during_run", product, 64'd0);
    wait_done(lat, bcnt, c1);
    @(negedge clk);

    // Start while busy and operand changes mid-run are ignored
    ds = done_seen;
    sb.push_back(64'd42);
    start_op(32'd7, 32'd6);
    repeat (9) @(negedge clk);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(lat, bcnt, c1);
    repeat (40) @(negedge clk);
    check("ignore_busy_one_done", 64'(done_seen - ds), 64'd1);

    // Back-to-back: start held through the run and the DONE cycle
    sb.push_back(64'd42);
    sb.push_back(64'h100000000);
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    @(negedge clk);
    a = 32'd2;
    b = 32'h80000000;
    wait_done(lat, bcnt, c1);
    check("b2b_first_latency", 64'(lat), 64'd32);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", {63'd0, busy}, 64'd1);
    wait_done(lat, bcnt, c2);
    check("b2b_done_spacing", 64'(c2 - c1), 64'd33);
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    start_op(32'd5, 32'd5);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",    {63'd0, busy}, 64'd0);
    check("arst_done",    {63'd0, done}, 64'd0);
    check("arst_product", product, 64'd0);
    check("arst_result",  {32'd0, result}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ds = done_seen;
    repeat (40) @(negedge clk);
    check("arst_no_spurious_done", 64'(done_seen - ds), 64'd0);
    check("arst_idle_busy", {63'd0, busy}, 64'd0);

    sb.push_back(64'd16);
    start_op(32'd4, 32'd4);
    wait_done(lat, bcnt, c1);
    check("post_reset_latency", 64'(lat), 64'd32);
    repeat (3) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
